fsm_modo_reto_param: RTL and testbench



---
 rtl/fsm_reto_pkg.sv | 57 +++++
 rtl/reto_timer.sv | 36 +++
 rtl/fsm_modo_reto_param.sv | 197 +++++++++++++++++++
 tb/tb_fsm_modo_reto_param.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_reto_pkg.sv
// -----------------------------------------------------------------------------
// fsm_reto_pkg
// Shared definitions for the challenge-mode game FSM:
//   - 4-bit state encodings (also exported on the debug state/next ports)
//   - clog2        : ceiling log2, usable in constant expressions
//   - onehot_to_idx: converts a player key to a note index plus a flag that
//                    is set only when exactly one bit is high
// -----------------------------------------------------------------------------
package fsm_reto_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_PLAY     = 4'd2;
    localparam logic [3:0] S_WAIT_IN  = 4'd3;
    localparam logic [3:0] S_CHECK    = 4'd4;
    localparam logic [3:0] S_ROUND_OK = 4'd5;
    localparam logic [3:0] S_MISS     = 4'd6;
    localparam logic [3:0] S_FAIL     = 4'd7;
    localparam logic [3:0] S_WIN      = 4'd8;

    // Widest key vector the decoder accepts (NOTE_W up to 6).
    localparam int ONEHOT_MAX_W = 64;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } onehot_t;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A zero or multi-hot vector yields valid=0, so it can never match a note.
    function automatic onehot_t onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] vec);
        onehot_t res;
        int      cnt;
        res = '0;
        cnt = 0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (vec[i]) begin
                cnt++;
                res.idx = 6'(i);
            end
        end
        res.valid = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/reto_timer.sv
// -----------------------------------------------------------------------------
// reto_timer
// Loadable down-counter shared by note playback and the input timeout.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_load     : load i_val (has priority over i_en)
//   i_en       : decrement by one, stopping at zero
//   i_val      : value to load
//   o_zero     : counter is zero
// -----------------------------------------------------------------------------
module reto_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsm_modo_reto_param.sv
// -----------------------------------------------------------------------------
// fsm_modo_reto_param
// Simon-style challenge game controller. Round r plays latched notes 0..r-1,
// then waits for r one-hot key presses, each within TIMEOUT cycles.
// Tracks lives, a saturating score and a won/lost flag.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   inicio            : start pulse (from IDLE, FAIL or WIN)
//   busNotas          : note sequence, note i at [i*NOTE_W +: NOTE_W]
//   notaUsuario       : player key, one-hot; valid with datoListo strobe
//   notaSalida        : note being played, notaValida qualifies it
//   juegoListo        : waiting for player input
//   cargarSecuencia   : pulse when busNotas is latched
//   contarNotas       : pulse in the last cycle of each played note
//   finJuego, exito   : game over, and won (1) / lost (0)
//   ronda, puntaje,
//   vidas             : round length, score, remaining lives
//   state, next       : registered / combinational state, for debug
// -----------------------------------------------------------------------------
module fsm_modo_reto_param
    import fsm_reto_pkg::*;
#(
    parameter int NUM_NOTES  = 10,
    parameter int NOTE_W     = 3,
    parameter int NOTE_TICKS = 25000000,
    parameter int TIMEOUT    = 250000000,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               inicio,
    input  logic [NUM_NOTES*NOTE_W-1:0]        busNotas,
    input  logic [2**NOTE_W-1:0]               notaUsuario,
    input  logic                               datoListo,
    output logic [NOTE_W-1:0]                  notaSalida,
    output logic                               notaValida,
    output logic                               juegoListo,
    output logic                               cargarSecuencia,
    output logic                               contarNotas,
    output logic                               finJuego,
    output logic                               exito,
    output logic [$clog2(NUM_NOTES+1)-1:0]     ronda,
    output logic [SCORE_W-1:0]                 puntaje,
    output logic [3:0]                         vidas,
    output logic [3:0]                         state,
    output logic [3:0]                         next
);

    localparam int RW   = $clog2(NUM_NOTES + 1);
    localparam int KW   = 2 ** NOTE_W;
    localparam int TMAX = (NOTE_TICKS > TIMEOUT) ? NOTE_TICKS : TIMEOUT;
    localparam int TW   = clog2(TMAX + 1);

    logic [3:0]                  r_state;
    logic [NUM_NOTES*NOTE_W-1:0] r_bus;
    logic [KW-1:0]               r_key;
    logic [RW-1:0]               r_idx;
    logic [RW-1:0]               r_ronda;
    logic [SCORE_W-1:0]          r_puntaje;
    logic [3:0]                  r_vidas;

    logic [3:0]        w_next;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic [TW-1:0]     w_tmr_val;
    logic              w_tmr_zero;
    logic [NOTE_W-1:0] w_note;
    logic [RW-1:0]     w_idx_inc;
    logic              w_last_note;
    onehot_t           w_key_info;
    logic              w_match;

    // Same index serves playback position and expected-input position.
    assign w_note      = NOTE_W'(r_bus >> (r_idx * NOTE_W));
    assign w_idx_inc   = r_idx + RW'(1);
    assign w_last_note = (w_idx_inc == r_ronda);
    assign w_key_info  = onehot_to_idx(ONEHOT_MAX_W'(r_key));
    assign w_match     = w_key_info.valid && (w_key_info.idx == 6'(w_note));

    reto_timer #(
        .W(TW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_tmr_load),
        .i_en   (w_tmr_en),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    // Counter is loaded with length-1 so that zero marks the final cycle of
    // a note, or the last cycle in which input is still accepted.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        w_tmr_val  = TW'(NOTE_TICKS - 1);
        case (r_state)
            S_LOAD, S_ROUND_OK, S_MISS: w_tmr_load = 1'b1;
            S_PLAY: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    if (w_last_note) w_tmr_val = TW'(TIMEOUT - 1);
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_WAIT_IN: w_tmr_en = 1'b1;
            S_CHECK: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(TIMEOUT - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (inicio) w_next = S_LOAD;
            S_LOAD:     w_next = S_PLAY;
            S_PLAY:     if (w_tmr_zero && w_last_note) w_next = S_WAIT_IN;
            S_WAIT_IN: begin
                // A strobe on the final cycle still counts as input.
                if (datoListo)       w_next = S_CHECK;
                else if (w_tmr_zero) w_next = S_MISS;
            end
            S_CHECK: begin
                if (!w_match)        w_next = S_MISS;
                else if (w_last_note) w_next = S_ROUND_OK;
                else                 w_next = S_WAIT_IN;
            end
            S_ROUND_OK: w_next = (r_ronda == RW'(NUM_NOTES)) ? S_WIN : S_PLAY;
            S_MISS:     w_next = (r_vidas <= 4'd1) ? S_FAIL : S_PLAY;
            S_FAIL,
            S_WIN:      if (inicio) w_next = S_LOAD;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) r_bus <= busNotas;
        if ((r_state == S_WAIT_IN) && datoListo) r_key <= notaUsuario;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ronda   <= '0;
            r_puntaje <= '0;
            r_vidas   <= 4'(LIVES);
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    r_idx     <= '0;
                    r_ronda   <= RW'(1);
                    r_puntaje <= '0;
                    r_vidas   <= 4'(LIVES);
                end
                S_PLAY: begin
                    if (w_tmr_zero) r_idx <= w_last_note ? '0 : w_idx_inc;
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_idx <= w_idx_inc;
                        if (r_puntaje != '1) r_puntaje <= r_puntaje + SCORE_W'(1);
                    end
                end
                S_ROUND_OK: begin
                    r_idx <= '0;
                    if (r_ronda != RW'(NUM_NOTES)) r_ronda <= r_ronda + RW'(1);
                end
                S_MISS: begin
                    r_idx <= '0;
                    if (r_vidas != 4'd0) r_vidas <= r_vidas - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign notaSalida      = (r_state == S_PLAY) ? w_note : '0;
    assign notaValida      = (r_state == S_PLAY);
    assign juegoListo      = (r_state == S_WAIT_IN);
    assign cargarSecuencia = (r_state == S_LOAD);
    assign contarNotas     = (r_state == S_PLAY) && w_tmr_zero;
    assign finJuego        = (r_state == S_FAIL) || (r_state == S_WIN);
    assign exito           = (r_state == S_WIN);
    assign ronda           = r_ronda;
    assign puntaje         = r_puntaje;
    assign vidas           = r_vidas;
    assign state           = r_state;
    assign next            = w_next;

endmodule

// File: tb/tb_fsm_modo_reto_param.sv
// -----------------------------------------------------------------------------
// tb_fsm_modo_reto_param
// Directed game scenarios plus randomized games for fsm_modo_reto_param.
// The reference model tracks the game as plain rules: the note list, round
// length, score and lives, and what each key press or timeout must do.
// -----------------------------------------------------------------------------
module tb_fsm_modo_reto_param;

    localparam int NN = 4;
    localparam int NW = 3;
    localparam int NT = 4;
    localparam int TO = 20;
    localparam int LV = 2;
    localparam int SW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           inicio;
    logic [NN*NW-1:0] busNotas;
    logic [7:0]     notaUsuario;
    logic           datoListo;
    logic [NW-1:0]  notaSalida;
    logic           notaValida;
    logic           juegoListo;
    logic           cargarSecuencia;
    logic           contarNotas;
    logic           finJuego;
    logic           exito;
    logic [2:0]     ronda;
    logic [SW-1:0]  puntaje;
    logic [3:0]     vidas;
    logic [3:0]     state;
    logic [3:0]     next;

    fsm_modo_reto_param #(
        .NUM_NOTES(NN), .NOTE_W(NW), .NOTE_TICKS(NT),
        .TIMEOUT(TO), .LIVES(LV), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .busNotas(busNotas),
        .notaUsuario(notaUsuario), .datoListo(datoListo),
        .notaSalida(notaSalida), .notaValida(notaValida),
        .juegoListo(juegoListo), .cargarSecuencia(cargarSecuencia),
        .contarNotas(contarNotas), .finJuego(finJuego), .exito(exito),
        .ronda(ronda), .puntaje(puntaje), .vidas(vidas),
        .state(state), .next(next)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_cargar = 0;
    int n_contar = 0;

    always @(negedge clk) begin
        if (cargarSecuencia) n_cargar++;
        if (contarNotas)     n_contar++;
    end

    // Reference model of the game.
    int seq [NN];
    int m_rnd;
    int m_score;
    int m_lives;
    // Scripted actions: 0 correct, 1 wrong key, 2 timeout, 3 multi-hot, 4 zero key.
    int script [$];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_state", state, 0);
        chk("rst_next", next, 0);
        chk("rst_notaSalida", notaSalida, 0);
        chk("rst_notaValida", notaValida, 0);
        chk("rst_juegoListo", juegoListo, 0);
        chk("rst_cargar", cargarSecuencia, 0);
        chk("rst_contar", contarNotas, 0);
        chk("rst_finJuego", finJuego, 0);
        chk("rst_exito", exito, 0);
        chk("rst_ronda", ronda, 0);
        chk("rst_puntaje", puntaje, 0);
        chk("rst_vidas", vidas, LV);
    endtask

    task automatic start_game(input logic [NN*NW-1:0] bus);
        busNotas = bus;
        for (int i = 0; i < NN; i++) seq[i] = int'((bus >> (NW * i)) & 12'h7);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        chk("load_pulse", cargarSecuencia, 1);
        chk("load_state", state, 1);
        m_rnd   = 1;
        m_score = 0;
        m_lives = LV;
        tick();
        chk("start_ronda", ronda, 1);
        chk("start_puntaje", puntaje, 0);
        chk("start_vidas", vidas, LV);
    endtask

    // Collects the played notes until input is requested; with noise on,
    // toggles inputs that must have no effect while notes are playing.
    task automatic watch_playback(input bit noise);
        int q [$];
        int cnt_c;
        int cyc;
        cnt_c = 0;
        cyc = 0;
        while (!juegoListo && cyc < 200) begin
            if (notaValida) q.push_back(int'(notaSalida));
            if (contarNotas) cnt_c++;
            if (noise && state == 4'd2) begin
                datoListo   = 1'($urandom_range(0, 1));
                inicio      = 1'($urandom_range(0, 1));
                notaUsuario = 8'($urandom);
                busNotas    = 12'($urandom);
            end
            tick();
            cyc++;
        end
        datoListo = 1'b0;
        inicio    = 1'b0;
        chk("play_reaches_input", juegoListo, 1);
        chk("play_len", q.size(), m_rnd * NT);
        chk("play_contar", cnt_c, m_rnd);
        foreach (q[k]) chk($sformatf("play_note_r%0d_k%0d", m_rnd, k), q[k], seq[k / NT]);
    endtask

    task automatic press(input logic [7:0] k);
        datoListo   = 1'b1;
        notaUsuario = k;
        tick();
        datoListo   = 1'b0;
        notaUsuario = 8'($urandom);
    endtask

    task automatic play_round(output bit over);
        int idx;
        bit missed;
        int act;
        int ex;
        int r;
        int wait_c;
        logic [7:0] k;
        idx = 0;
        missed = 1'b0;
        over = 1'b0;
        while (idx < m_rnd && !missed) begin
            chk("wait_juegoListo", juegoListo, 1);
            chk("wait_notaValida", notaValida, 0);
            ex = seq[idx];
            if (script.size() > 0) begin
                act = script.pop_front();
            end else begin
                r = int'($urandom_range(0, 99));
                act = (r < 80) ? 0 : (r < 88) ? 1 : (r < 93) ? 2 : (r < 97) ? 3 : 4;
            end
            if (act == 2) begin
                wait_c = 0;
                while (juegoListo && wait_c < 100) begin
                    tick();
                    wait_c++;
                end
                chk("timeout_len", wait_c, TO);
                chk("timeout_state", state, 6);
                missed = 1'b1;
            end else begin
                case (act)
                    0:       k = 8'(1 << ex);
                    1:       k = 8'(1 << ((ex + 1) % 8));
                    3:       k = 8'(1 << ex) | 8'(1 << ((ex + 3) % 8));
                    default: k = 8'h00;
                endcase
                press(k);
                chk("check_state", state, 4);
                chk("check_next", next, (act == 0) ? ((idx + 1 == m_rnd) ? 5 : 3) : 6);
                tick();
                if (act == 0) begin
                    idx++;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    chk("score_after_hit", puntaje, m_score);
                    chk("state_after_hit", state, (idx == m_rnd) ? 5 : 3);
                end else begin
                    chk("state_after_miss", state, 6);
                    missed = 1'b1;
                end
            end
        end
        tick();
        chk("round_puntaje", puntaje, m_score);
        if (missed) begin
            m_lives--;
            chk("miss_vidas", vidas, m_lives);
            chk("miss_ronda", ronda, m_rnd);
            if (m_lives == 0) begin
                chk("lose_finJuego", finJuego, 1);
                chk("lose_exito", exito, 0);
                chk("lose_state", state, 7);
                over = 1'b1;
            end else begin
                chk("replay_state", state, 2);
            end
        end else if (m_rnd == NN) begin
            chk("win_finJuego", finJuego, 1);
            chk("win_exito", exito, 1);
            chk("win_state", state, 8);
            over = 1'b1;
        end else begin
            m_rnd++;
            chk("next_ronda", ronda, m_rnd);
            chk("next_state", state, 2);
        end
    endtask

    // stop_rnd > 0 leaves the game waiting for input in that round.
    task automatic play_game(input logic [NN*NW-1:0] bus, input int stop_rnd, input bit noise);
        bit over;
        int guard;
        over = 1'b0;
        guard = 0;
        start_game(bus);
        while (!over && guard < 40) begin
            watch_playback(noise);
            if (m_rnd == stop_rnd) return;
            play_round(over);
            guard++;
        end
        chk("game_over", over, 1);
    endtask

    initial begin
        int c0;
        int t0;
        reset       = 1'b1;
        inicio      = 1'b0;
        datoListo   = 1'b0;
        notaUsuario = 8'h00;
        busNotas    = 12'h1D5;
        tick();
        tick();
        chk_reset_outputs();
        reset = 1'b0;

        // IDLE ignores strobes other than inicio.
        datoListo = 1'b1;
        tick();
        datoListo = 1'b0;
        chk("idle_ignores_dato", state, 0);
        tick();

        // Perfect game.
        c0 = n_cargar;
        t0 = n_contar;
        for (int i = 0; i < 10; i++) script.push_back(0);
        play_game(12'h1D5, 0, 1'b0);
        tick();
        chk("perfect_cargar_count", n_cargar - c0, 1);
        chk("perfect_contar_count", n_contar - t0, 10);
        chk("perfect_ronda", ronda, 4);
        chk("perfect_puntaje", puntaje, 10);
        chk("perfect_vidas", vidas, 2);
        chk("perfect_exito", exito, 1);

        // Wrong key in round 2 (8'h08 where 8'h04 is due), then win; started
        // straight from WIN, with ignored inputs toggled during playback.
        script = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        play_game(12'h1D5, 0, 1'b1);
        chk("wrongkey_vidas", vidas, 1);
        chk("wrongkey_puntaje", puntaje, 11);

        // Two timeouts in round 1 end the game.
        script = '{2, 2};
        play_game(12'h1D5, 0, 1'b0);
        chk("timeout_puntaje", puntaje, 0);

        // Multi-hot (8'h21) and zero keys are mismatches.
        script = '{3, 4};
        play_game(12'h1D5, 0, 1'b0);
        chk("illegal_vidas", vidas, 0);

        // Reset while waiting for input in round 3.
        script = '{0, 0, 0};
        play_game(12'h1D5, 3, 1'b0);
        chk("pre_reset_state", state, 3);
        chk("pre_reset_ronda", ronda, 3);
        reset = 1'b1;
        tick();
        chk_reset_outputs();
        reset = 1'b0;
        tick();
        script.delete();

        // Randomized games on random sequences.
        for (int g = 0; g < 5; g++) play_game(12'($urandom), 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
